// File: rtl/freq_meter_param.sv
`default_nettype none
// ============================================================================
// Module      : freq_meter_param
// Description : Gated frequency meter. Counts synchronised sigin edges over a
//               GATE_CYCLES window and publishes a saturating count.
// Revision    : 1.0 - initial release
// ============================================================================
module freq_meter_param #(
    parameter int CNT_W       = 16,
    parameter int GATE_CYCLES = 1000000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sigin,
    input  logic             en,
    input  logic             edge_mode,
    output logic [CNT_W-1:0] freq,
    output logic             freq_valid,
    output logic             overflow,
    output logic             busy
);

    localparam int                GATE_W    = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    state_t                 state_q, state_d;
    logic [GATE_W-1:0]      gate_q, gate_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   win_ovf_q, win_ovf_d;
    logic [CNT_W-1:0]       freq_q, freq_d;
    logic                   freq_valid_q, freq_valid_d;
    logic                   overflow_q, overflow_d;

    logic                   sync_out, rise, fall, edge_evt;
    logic                   cnt_at_max;
    logic [CNT_W-1:0]       cnt_next;
    logic                   ovf_next;

    // Synchroniser and edge detector run regardless of en so that the
    // first window after enabling sees a settled previous sample.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], sigin};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    assign sync_out   = sync_q[SYNC_STAGES-1];
    assign rise       = sync_out & ~prev_q;
    assign fall       = ~sync_out & prev_q;
    assign edge_evt   = rise | (edge_mode & fall);

    assign cnt_at_max = (cnt_q == CNT_MAX);
    assign cnt_next   = (edge_evt && !cnt_at_max) ? cnt_q + CNT_W'(1) : cnt_q;
    assign ovf_next   = win_ovf_q | (edge_evt & cnt_at_max);

    always_comb begin
        state_d      = state_q;
        gate_d       = gate_q;
        cnt_d        = cnt_q;
        win_ovf_d    = win_ovf_q;
        freq_d       = freq_q;
        overflow_d   = overflow_q;
        freq_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                gate_d    = '0;
                cnt_d     = '0;
                win_ovf_d = 1'b0;
                if (en) state_d = RUN;
            end
            RUN: begin
                if (gate_q == GATE_LAST) begin
                    // Publish includes the final cycle's event; next window
                    // starts at gate 0 in the very next cycle.
                    freq_d       = cnt_next;
                    overflow_d   = ovf_next;
                    freq_valid_d = 1'b1;
                    gate_d       = '0;
                    cnt_d        = '0;
                    win_ovf_d    = 1'b0;
                    if (!en) state_d = IDLE;
                end else if (!en) begin
                    state_d   = IDLE;
                    gate_d    = '0;
                    cnt_d     = '0;
                    win_ovf_d = 1'b0;
                end else begin
                    gate_d    = gate_q + GATE_W'(1);
                    cnt_d     = cnt_next;
                    win_ovf_d = ovf_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q       <= '0;
            prev_q       <= 1'b0;
            state_q      <= IDLE;
            gate_q       <= '0;
            cnt_q        <= '0;
            win_ovf_q    <= 1'b0;
            freq_q       <= '0;
            freq_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            prev_q       <= prev_d;
            state_q      <= state_d;
            gate_q       <= gate_d;
            cnt_q        <= cnt_d;
            win_ovf_q    <= win_ovf_d;
            freq_q       <= freq_d;
            freq_valid_q <= freq_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign freq       = freq_q;
    assign freq_valid = freq_valid_q;
    assign overflow   = overflow_q;
    assign busy       = (state_q == RUN);

endmodule
`default_nettype wire

// File: tb/tb_freq_meter_param.sv
`default_nettype none
`timescale 1ns/100ps
// ============================================================================
// Module      : tb_freq_meter_param
// Description : Scoreboard bench for freq_meter_param (16-bit and 4-bit DUTs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_freq_meter_param;

    localparam int GATE = 200;

    typedef struct {
        bit          chk_val;  // compare freq/overflow
        logic [15:0] f;
        bit          ovf;
        int          tmode;    // 0 none, 1 gap from previous valid, 2 absolute cycle
        int          tval;
    } exp_t;

    logic        clk, rst_n, sigin, en, en4, edge_mode;
    logic [15:0] freq;
    logic [3:0]  freq4;
    logic        freq_valid, overflow, busy;
    logic        freq_valid4, overflow4, busy4;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    bit   sig_run = 1'b1;
    exp_t q[$];
    exp_t q4[$];

    freq_meter_param #(.CNT_W(16), .GATE_CYCLES(GATE), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sigin(sigin), .en(en), .edge_mode(edge_mode),
        .freq(freq), .freq_valid(freq_valid), .overflow(overflow), .busy(busy)
    );

    freq_meter_param #(.CNT_W(4), .GATE_CYCLES(GATE), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .sigin(sigin), .en(en4), .edge_mode(edge_mode),
        .freq(freq4), .freq_valid(freq_valid4), .overflow(overflow4), .busy(busy4)
    );

    initial begin
        clk = 1'b0;
        forever #1 clk = ~clk;
    end

    // sigin toggles every 20 ns, midway between clk edges
    initial begin
        sigin = 1'b0;
        #10.5;
        forever begin
            if (sig_run) sigin = ~sigin;
            #20;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitors ----------------
    int   last_v  = 0;
    int   last_v4 = 0;
    logic [15:0] prev_freq = '0;
    logic        prev_ovf  = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (!freq_valid) begin
                chk("freq_hold", {15'd0, (freq !== prev_freq) || (overflow !== prev_ovf)}, 32'd0);
            end else if (q.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                if (e.chk_val) begin
                    chk("freq", {16'd0, freq}, {16'd0, e.f});
                    chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
                end
                if (e.tmode == 1) chk("valid_gap", cyc - last_v, e.tval);
                if (e.tmode == 2) chk("valid_cycle", cyc, e.tval);
            end
            if (freq_valid) last_v = cyc;
        end
        prev_freq = freq;
        prev_ovf  = overflow;
    end

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && freq_valid4) begin
            if (q4.size() == 0) begin
                chk("unexpected_valid4", 32'd1, 32'd0);
            end else begin
                e = q4.pop_front();
                if (e.chk_val) begin
                    chk("freq4", {28'd0, freq4}, {16'd0, e.f});
                    chk("overflow4", {31'd0, overflow4}, {31'd0, e.ovf});
                end
                if (e.tmode == 1) chk("valid_gap4", cyc - last_v4, e.tval);
                if (e.tmode == 2) chk("valid_cycle4", cyc, e.tval);
            end
            last_v4 = cyc;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push(input int which, input bit cv, input int f, input bit o,
                        input int tm, input int tv);
        exp_t e;
        e.chk_val = cv;
        e.f       = 16'(f);
        e.ovf     = o;
        e.tmode   = tm;
        e.tval    = tv;
        if (which == 0) q.push_back(e);
        else            q4.push_back(e);
    endtask

    task automatic drain(input int which, input string name);
        int n = 0;
        while (((which == 0) ? q.size() : q4.size()) != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic chk_reset_state(input string name);
        chk({name, "_freq"},  {16'd0, freq}, 32'd0);
        chk({name, "_valid"}, {31'd0, freq_valid}, 32'd0);
        chk({name, "_ovf"},   {31'd0, overflow}, 32'd0);
        chk({name, "_busy"},  {31'd0, busy}, 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int c0;
        rst_n = 1'b0; en = 1'b0; en4 = 1'b0; edge_mode = 1'b0;
        #5.5;
        chk_reset_state("reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // rising edges only: 10 per window
        en = 1'b1; c0 = cyc;
        push(0, 0, 0, 0, 2, c0 + GATE + 1);
        for (int i = 0; i < 3; i++) push(0, 1, 10, 0, 1, GATE);
        @(negedge clk);
        chk("busy_run", {31'd0, busy}, 32'd1);
        drain(0, "rise_only");

        // both edges: 20 per window
        edge_mode = 1'b1;
        push(0, 0, 0, 0, 1, GATE);
        for (int i = 0; i < 2; i++) push(0, 1, 20, 0, 1, GATE);
        drain(0, "both_edges");

        edge_mode = 1'b0;
        push(0, 0, 0, 0, 1, GATE);
        for (int i = 0; i < 2; i++) push(0, 1, 10, 0, 1, GATE);
        drain(0, "back_rise");

        // en dropped at gate count 100 for 50 cycles
        repeat (100) @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            chk("gap_busy", {31'd0, busy}, 32'd0);
            if (i % 10 == 0) chk("gap_freq", {16'd0, freq}, 32'd10);
        end
        en = 1'b1; c0 = cyc;
        push(0, 1, 10, 0, 2, c0 + GATE + 1);
        push(0, 1, 10, 0, 1, GATE);
        drain(0, "en_gap");

        // asynchronous reset mid-window
        repeat (60) @(negedge clk);
        #0.3 rst_n = 1'b0;
        #0.5 chk_reset_state("async_rst");
        #2.5 rst_n = 1'b1;
        c0 = cyc;
        push(0, 0, 0, 0, 2, c0 + GATE + 1);
        push(0, 1, 10, 0, 1, GATE);
        drain(0, "post_rst");

        // sigin frozen
        sig_run = 1'b0;
        push(0, 0, 0, 0, 1, GATE);
        for (int i = 0; i < 2; i++) push(0, 1, 0, 0, 1, GATE);
        drain(0, "frozen");
        sig_run = 1'b1;

        // 4-bit counter saturation, then back to rising only
        en = 1'b0;
        edge_mode = 1'b1;
        repeat (20) @(negedge clk);
        en4 = 1'b1; c0 = cyc;
        push(1, 0, 0, 0, 2, c0 + GATE + 1);
        for (int i = 0; i < 2; i++) push(1, 1, 15, 1, 1, GATE);
        drain(1, "sat4");
        edge_mode = 1'b0;
        push(1, 0, 0, 0, 1, GATE);
        for (int i = 0; i < 2; i++) push(1, 1, 10, 0, 1, GATE);
        drain(1, "unsat4");

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/freq_meter_param.md
Name: freq_meter_param

Overview:
Parametrised gated frequency meter, the successor to freq_counter.
- Counts edges of an asynchronous input `sigin` over a fixed gate window of `GATE_CYCLES` clk cycles.
- At window end, publishes the count with a one-cycle valid strobe.
- Adds a configurable result width, an input synchroniser, rising-only or both-edge counting, enable control, saturation with an overflow flag, and async reset.
- Sits between external pin sampling and display/readout logic.

Parameters:
- CNT_W, 16: width of the edge counter and the `freq` result.
- GATE_CYCLES, 1000000: gate window length in clk cycles; legal values are ≥2.
- SYNC_STAGES, 2: number of flip-flops synchronising `sigin`; legal values are ≥2.

Ports:
- clk, input, 1: system clock; all logic is on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- sigin, input, 1: measured signal, asynchronous to clk.
- en, input, 1: measurement enable.
- edge_mode, input, 1: 0 counts rising edges only; 1 counts rising and falling edges.
- freq, output, CNT_W: edge count of the last completed window.
- freq_valid, output, 1: one-cycle pulse when `freq` updates.
- overflow, output, 1: set when the last completed window's count saturated.
- busy, output, 1: high while a window is in progress.

Behaviour:
- Reset (rst_n=0, asynchronous): all of the following clear to 0:
  - `freq`, `freq_valid`, `overflow`, `busy`
  - gate counter and edge counter
  - all sync flops and the previous-sample flop
- Release of rst_n is synchronous to clk.
- Synchroniser: a chain of `SYNC_STAGES` flops, followed by one previous-sample flop. This path always runs, regardless of `en`.
  - `rise` = sync_out & ~prev; `fall` = ~sync_out & prev.
  - `edge_evt` = rise | (edge_mode & fall).
  - Latency from a sigin transition to `edge_evt` is `SYNC_STAGES`+1 clk cycles.
- State machine: IDLE and RUN.
  - IDLE: `busy`=0. The gate counter and edge counter are held at 0.
  - IDLE → RUN on the first cycle with en=1.
  - RUN: `busy`=1. The gate counter counts 0..GATE_CYCLES-1, incrementing by 1 each cycle.
  - Each cycle in RUN with `edge_evt`=1 increments the edge counter.
  - The edge counter saturates at 2^CNT_W−1. A sticky window-overflow bit sets when an increment is attempted at the maximum value.
- Window end (RUN with gate counter == GATE_CYCLES-1):
  - The count including this cycle's `edge_evt` (saturated) becomes next `freq`.
  - The window-overflow bit, including this cycle's saturation, becomes next `overflow`.
  - `freq_valid`=1 for exactly the following cycle.
  - The gate counter, edge counter and window-overflow bit clear, and a new window starts immediately (stay in RUN) if en=1. Otherwise go to IDLE.
- Windows are back-to-back; no edge is lost or double-counted across a window boundary.
- en deasserted mid-window: in the next cycle go to IDLE and discard the partial counts. No `freq_valid` is generated. `freq` and `overflow` hold their last published values.
- en reasserted: a fresh full window starts at gate count 0.
- edge_mode change mid-window: takes effect on `edge_evt` the same cycle. The window is not restarted, and that window's result mixes both modes (documented, not an error).
- `freq` and `overflow` change only in the cycle `freq_valid` is high (or at reset).
- Reset mid-window: all state clears immediately; no valid pulse is produced.

Test Plan:
Common setup for all scenarios: clk period 2 ns; sigin toggles every 20 ns (40 ns period = 20 clk cycles). Unless stated otherwise: GATE_CYCLES=200, CNT_W=16, SYNC_STAGES=2. Checks start from the second window.

1. edge_mode=0, en=1 → `freq_valid` pulses every 200 cycles, and `freq`=10 on each pulse; `overflow`=0.
2. edge_mode=1 → `freq`=20 each window.
3. CNT_W=4, edge_mode=1 → `freq`=15 and `overflow`=1 every window. Then switch edge_mode=0 → after one transitional window, `freq`=10 and `overflow`=0.
4. Drop en at gate count 100, hold low 50 cycles, then raise it → no `freq_valid` during the gap, and `freq` holds its prior value 10. The next pulse arrives 201 cycles after en rises, with `freq`=10.
5. Assert rst_n=0 for 3 ns mid-window, asynchronous to clk → `freq`=0, `freq_valid`=0, `overflow`=0 and `busy`=0 immediately. After release, the first valid pulse arrives ≥200 cycles later.
6. sigin held constant for a whole window → `freq`=0, with `freq_valid` still pulsing every 200 cycles.
